// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the RV32M multiply/divide sequencer.
//   op_e     : operation encoding, keyed directly by the instruction func3 field
//   state_e  : sequencer FSM states
//   is_div   : op belongs to the divide/remainder class
//   a_signed : rs1 operand is interpreted as two's complement
//   b_signed : rs2 operand is interpreted as two's complement
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_RUN,
      ST_FIX,
      ST_DONE
   } state_e;

   function automatic logic is_div(input op_e op);
      case (op)
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

   function automatic logic a_signed(input op_e op);
      case (op)
         OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic b_signed(input op_e op);
      case (op)
         OP_MULH, OP_DIV, OP_REM: return 1'b1;
         default:                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: execute-stage handshake for the multiply/divide sequencer.
//   start/flush/func3/op_a/op_b : issued by execute (master)
//   busy_o/done_o/result_o      : returned by the sequencer (slave)
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             flush;
   logic [2:0]       func3;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;

   modport master (
      output start, flush, func3, op_a, op_b,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start, flush, func3, op_a, op_b,
      output busy_o, done_o, result_o
   );
endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiply / restoring divide datapath.
//   clk, rst_n : clock, synchronous active-low reset
//   i_load     : take operand magnitudes, record signs, clear accumulator
//   i_step     : one multiply or divide iteration
//   i_fix      : sign-correct, apply RISC-V special cases, register result
//   i_op       : latched operation
//   i_a, i_b   : latched raw operands (rs1, rs2)
//   o_result   : registered result, held until the next fix
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_fix,
   input  op_e              i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result
);

   // r_hi: product high half / partial remainder
   // r_lo: multiplier then product low half / dividend then quotient
   logic [WIDTH-1:0] r_hi, r_lo, r_mcand, r_result;
   logic             r_neg, r_neg_rem;

   logic             w_a_neg, w_b_neg;
   logic [WIDTH-1:0] w_a_mag, w_b_mag;
   logic [WIDTH:0]   w_sum, w_shrem, w_diff;
   logic [2*WIDTH-1:0] w_prod, w_prod_s;
   logic [WIDTH-1:0] w_quo, w_rem, w_fixed;
   logic             w_dz, w_ovf, w_mul_zero;

   assign w_a_neg = a_signed(i_op) & i_a[WIDTH-1];
   assign w_b_neg = b_signed(i_op) & i_b[WIDTH-1];
   assign w_a_mag = w_a_neg ? -i_a : i_a;
   assign w_b_mag = w_b_neg ? -i_b : i_b;

   // Multiply step: the carry out of the add lands in bit WIDTH and is
   // shifted back into the top of r_hi.
   assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);

   // Divide step: the partial remainder is always below the divisor, so the
   // shifted value fits WIDTH+1 bits and w_diff[WIDTH] is the borrow.
   assign w_shrem = {r_hi, r_lo[WIDTH-1]};
   assign w_diff  = w_shrem - {1'b0, r_mcand};

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = r_neg ? -w_prod : w_prod;
   assign w_quo    = r_neg ? -r_lo : r_lo;
   assign w_rem    = r_neg_rem ? -r_hi : r_hi;

   assign w_dz       = (i_b == '0);
   assign w_ovf      = (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);
   // Forced zero covers the early-out path where the loop never ran.
   assign w_mul_zero = (i_a == '0) || (i_b == '0);

   always_comb begin
      w_fixed = '0;
      case (i_op)
         OP_MUL:                       w_fixed = w_mul_zero ? '0 : w_prod_s[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_fixed = w_mul_zero ? '0 : w_prod_s[2*WIDTH-1:WIDTH];
         OP_DIV:  w_fixed = w_dz ? '1  : (w_ovf ? {1'b1, {(WIDTH-1){1'b0}}} : w_quo);
         OP_DIVU: w_fixed = w_dz ? '1  : w_quo;
         OP_REM:  w_fixed = w_dz ? i_a : (w_ovf ? '0 : w_rem);
         OP_REMU: w_fixed = w_dz ? i_a : w_rem;
         default: w_fixed = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_mcand   <= '0;
         r_neg     <= 1'b0;
         r_neg_rem <= 1'b0;
         r_result  <= '0;
      end else begin
         if (i_load) begin
            r_hi      <= '0;
            r_lo      <= w_a_mag;
            r_mcand   <= w_b_mag;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
         end else if (i_step) begin
            if (is_div(i_op)) begin
               r_hi <= w_diff[WIDTH] ? w_shrem[WIDTH-1:0] : w_diff[WIDTH-1:0];
               r_lo <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
            end else begin
               r_hi <= w_sum[WIDTH:1];
               r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
         end
         if (i_fix)
            r_result <= w_fixed;
      end
   end

   assign o_result = r_result;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for the execute stage.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : muldiv_if.slave (start, flush, func3, op_a, op_b in;
//                busy_o, done_o, result_o out)
// Latency is WIDTH+3 cycles from start to done_o. With MULDIV_EARLY_OUT_EN
// defined, zero divisors and zero multiply operands skip the iteration loop
// and complete in 3 cycles with identical results.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);

   state_e           r_state;
   logic [WIDTH-1:0] r_cnt;
   logic             r_done;
   op_e              r_op;
   logic [WIDTH-1:0] r_a, r_b;

   logic             w_early, w_load, w_step, w_fix;
   logic [WIDTH-1:0] w_result;

`ifdef MULDIV_EARLY_OUT_EN
   assign w_early = is_div(r_op) ? (r_b == '0) : ((r_a == '0) || (r_b == '0));
`else
   assign w_early = 1'b0;
`endif

   // Strobes are suppressed on flush so an aborted op never touches result_o.
   assign w_load = (r_state == ST_PREP) && !bus.flush;
   assign w_step = (r_state == ST_RUN)  && !bus.flush;
   assign w_fix  = (r_state == ST_FIX)  && !bus.flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_op    <= OP_MUL;
         r_a     <= '0;
         r_b     <= '0;
      end else begin
         r_done <= 1'b0;
         if (bus.flush) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: if (bus.start) begin
                  r_op    <= op_e'(bus.func3);
                  r_a     <= bus.op_a;
                  r_b     <= bus.op_b;
                  r_state <= ST_PREP;
               end
               ST_PREP: begin
                  r_cnt   <= '0;
                  r_state <= w_early ? ST_FIX : ST_RUN;
               end
               ST_RUN: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == WIDTH'(WIDTH-1))
                     r_state <= ST_FIX;
               end
               ST_FIX: begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
               // start seen here belongs to the retiring instruction
               ST_DONE: r_state <= ST_IDLE;
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_fix    (w_fix),
      .i_op     (r_op),
      .i_a      (r_a),
      .i_b      (r_b),
      .o_result (w_result)
   );

   assign bus.busy_o   = ((r_state == ST_IDLE) && bus.start && !bus.flush) ||
                         (r_state == ST_PREP) || (r_state == ST_RUN) ||
                         (r_state == ST_FIX);
   assign bus.done_o   = r_done;
   assign bus.result_o = w_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed plus randomized checks of muldiv_sequencer
// against an arithmetic reference model of the RV32M operations.
module tb_muldiv_sequencer;

   localparam int W   = 32;
   localparam int LAT = W + 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_if #(.WIDTH(W)) bus ();

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int passed = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference: RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      logic        [63:0] pu;
      logic signed [63:0] ps;
      int ia, ib;
      pu = {32'b0, a} * {32'b0, b};
      ia = $signed(a);
      ib = $signed(b);
      case (f)
         3'd0: return pu[31:0];
         3'd1: begin ps = longint'(ia) * longint'(ib); return ps[63:32]; end
         3'd2: begin ps = longint'(ia) * $signed({32'b0, b}); return ps[63:32]; end
         3'd3: return pu[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if ((f >= 3'd4) ? (b == 0) : (a == 0 || b == 0)) return 3;
`endif
      return LAT;
   endfunction

   // Issue one op at cycle 0 and follow it to completion.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      logic [31:0] exp_r, got_r;
      int exp_l, done_cyc;
      logic busy_ok, busy_done;
      exp_r = ref_result(f, a, b);
      exp_l = ref_lat(f, a, b);
      @(negedge clk);
      bus.start = 1'b1; bus.func3 = f; bus.op_a = a; bus.op_b = b;
      #1 check({tag, " busy@0"}, 32'(bus.busy_o), 32'd1);
      done_cyc = -1; busy_ok = 1'b1; busy_done = 1'b1; got_r = 'x;
      for (int c = 1; c <= LAT + 5 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            // scramble inputs: the sequencer must use the latched copies
            bus.start = 1'b0; bus.func3 = 3'($urandom);
            bus.op_a = $urandom; bus.op_b = $urandom;
         end
         #1;
         if (bus.done_o) begin
            done_cyc = c; got_r = bus.result_o; busy_done = bus.busy_o;
         end else if (!bus.busy_o) busy_ok = 1'b0;
      end
      check({tag, " latency"}, 32'(done_cyc), 32'(exp_l));
      check({tag, " result"}, got_r, exp_r);
      check({tag, " busy before done"}, 32'(busy_ok), 32'd1);
      check({tag, " busy in done"}, 32'(busy_done), 32'd0);
      @(negedge clk); #1;
      check({tag, " done one cycle"}, 32'(bus.done_o), 32'd0);
      check({tag, " result held"}, bus.result_o, exp_r);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int seen_done;
      bus.start = 1'b0; bus.flush = 1'b0; bus.func3 = '0; bus.op_a = '0; bus.op_b = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("reset busy", 32'(bus.busy_o), 32'd0);
      check("reset done", 32'(bus.done_o), 32'd0);
      check("reset result", bus.result_o, 32'd0);
      rst_n = 1'b1;

      // Directed vectors
      run_op(3'd0, 32'd7,         32'hFFFF_FFFD, "MUL 7*-3");
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "MULH min*min");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU max*max");
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         "MULHSU -1*2");
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         "DIV -7/2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         "REM -7/2");
      run_op(3'd5, 32'd100,       32'd7,         "DIVU 100/7");
      run_op(3'd7, 32'd100,       32'd7,         "REMU 100/7");
      run_op(3'd4, 32'd5,         32'd0,         "DIV 5/0");
      run_op(3'd6, 32'd5,         32'd0,         "REM 5/0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");
      run_op(3'd5, 32'd9,         32'd0,         "DIVU 9/0");
      run_op(3'd0, 32'd0,         32'h1234_5678, "MUL 0*x");

      // Flush at cycle 10
      @(negedge clk);
      bus.start = 1'b1; bus.func3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
      end
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      check("flush busy", 32'(bus.busy_o), 32'd0);
      check("flush done", 32'(bus.done_o), 32'd0);
      seen_done = 0;
      for (int c = 0; c < LAT + 5; c++) begin
         @(negedge clk); #1;
         if (bus.done_o) seen_done++;
      end
      check("flush no done", 32'(seen_done), 32'd0);
      run_op(3'd5, 32'd100, 32'd7, "DIVU after flush");

      // Reset at cycle 20 of a multiply
      @(negedge clk);
      bus.start = 1'b1; bus.func3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("midrst busy", 32'(bus.busy_o), 32'd0);
      check("midrst done", 32'(bus.done_o), 32'd0);
      check("midrst result", bus.result_o, 32'd0);
      rst_n = 1'b1;

      // Randomized operations
      for (int i = 0; i < 30; i++) begin
         logic [2:0] f;
         logic [31:0] a, b;
         f = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         run_op(f, a, b, $sformatf("rand%0d f%0d %h,%h", i, f, a, b));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
